// File: rtl/mem_pkg.sv
// Shared encodings and byte-enable helper for the data memory block.
// No logic of its own; purely types, constants and a pure function.
// Imported by the top level and the lane alignment sub-module.
package mem_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        SIZE_B   = 2'b00,
        SIZE_H   = 2'b01,
        SIZE_W   = 2'b10,
        SIZE_RSV = 2'b11
    } size_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Byte lanes touched by an access of the given size starting at lane.
    // Misaligned combinations are filtered by the caller before use.
    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SIZE_B:  be = 4'b0001 << lane;
            SIZE_H:  be = lane[1] ? 4'b1100 : 4'b0011;
            SIZE_W:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/data_memory_if.sv
// Request/response bus between the memory stage and the data memory.
// Response arrives one cycle after the accepting edge.
// req_ready is the only backpressure; responses cannot be stalled.
interface data_memory_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store data replication + byte enables, load lane extract + extension.
// Purely combinational, zero latency.
// No handshake; the caller decides when the results are used.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_lane,
    input  logic [31:0] st_data,
    output logic [31:0] st_word,
    output logic [3:0]  st_be,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_lane,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        ld_sign;

    // Store path: replicate the right-justified data into every lane it could
    // land in; the byte enables pick the lanes that are actually written.
    always_comb begin
        st_be   = byte_enable(st_size, st_lane);
        st_word = st_data;
        case (st_size)
            SIZE_B:  st_word = {4{st_data[7:0]}};
            SIZE_H:  st_word = {2{st_data[15:0]}};
            default: st_word = st_data;
        endcase
    end

    // Load path: pick the addressed lane(s) and extend to a full word.
    always_comb begin
        ld_byte = ld_word[{ld_lane, 3'b000} +: 8];
        ld_half = ld_lane[1] ? ld_word[31:16] : ld_word[15:0];
        ld_sign = 1'b0;
        ld_data = 32'h0;
        case (ld_size)
            SIZE_B: begin
                ld_sign = ~ld_unsigned & ld_byte[7];
                ld_data = {{24{ld_sign}}, ld_byte};
            end
            SIZE_H: begin
                ld_sign = ~ld_unsigned & ld_half[15];
                ld_data = {{16{ld_sign}}, ld_half};
            end
            SIZE_W:  ld_data = ld_word;
            default: ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Single-port byte-addressed data memory with post-reset hardware clear.
// Latency: response (valid/data/err) in the cycle after the accepting edge.
// Backpressure: req_ready low only while clearing; full throughput when ready.
module data_memory
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH          = 1024,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter bit          CLEAR_ON_RESET = 1'b1
)(
    input  logic clk,
    input  logic rst,
    data_memory_if.slave bus
);

    localparam int unsigned   AW   = $clog2(DEPTH);
    localparam logic [31:0]   SPAN = 32'(WORD_BYTES * DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    // FSM and clear sequencing
    state_e        state;
    state_e        state_nxt;
    logic [AW-1:0] clr_cnt;
    logic [AW-1:0] clr_cnt_nxt;
    logic          clr_wr;
    logic          ready;

    // Request decode
    logic [31:0]   off;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          in_range;
    logic          misalign;
    logic          req_err;
    logic          accept;
    logic          do_store;
    logic          do_load;

    // Array port
    logic [31:0]   mem [DEPTH];
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [31:0]   wr_data;
    logic [3:0]    wr_be;
    logic [31:0]   st_word;
    logic [3:0]    st_be;
    logic [31:0]   rd_word;

    // Response side
    logic          rsp_valid_q;
    logic          rsp_err_q;
    logic          load_ok;
    logic [1:0]    rsp_size;
    logic [1:0]    rsp_lane;
    logic          rsp_unsigned;
    logic [31:0]   ld_data;

    // Address translation, range and alignment checks for the presented request.
    always_comb begin
        off      = bus.req_addr - BASE_ADDR;
        idx      = off[AW+1:2];
        lane     = off[1:0];
        in_range = (off < SPAN);
        misalign = 1'b0;
        case (bus.req_size)
            SIZE_H:  misalign = lane[0];
            SIZE_W:  misalign = |lane;
            default: misalign = 1'b0;
        endcase
        req_err  = (bus.req_size == SIZE_RSV) | misalign | ~in_range;
        // Holding off acceptance during the reset edge keeps a stray request
        // from writing the array while the block is being reset.
        accept   = bus.req_valid & ready & ~rst;
        do_store = accept & ~req_err & bus.req_we;
        do_load  = accept & ~req_err & ~bus.req_we;
    end

    // Next-state logic: walk the clear counter through every word, then serve.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        clr_wr      = 1'b0;
        case (state)
            ST_CLEAR: begin
                if (!CLEAR_ON_RESET) begin
                    state_nxt = ST_READY;
                end else begin
                    clr_wr      = ~rst;
                    clr_cnt_nxt = clr_cnt + AW'(1);
                    if (clr_cnt == LAST) begin
                        state_nxt = ST_READY;
                    end
                end
            end
            ST_READY: state_nxt = ST_READY;
            default:  state_nxt = ST_CLEAR;
        endcase
    end

    assign ready         = (state == ST_READY);
    assign bus.req_ready = ready;

    // State register and clear counter; reset always restarts the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    mem_lane_align u_align (
        .st_size     (bus.req_size),
        .st_lane     (lane),
        .st_data     (bus.req_wdata),
        .st_word     (st_word),
        .st_be       (st_be),
        .ld_size     (rsp_size),
        .ld_lane     (rsp_lane),
        .ld_unsigned (rsp_unsigned),
        .ld_word     (rd_word),
        .ld_data     (ld_data)
    );

    // Single write port shared by the clear sequence and stores; the two never
    // coincide because requests are only accepted once the clear is done.
    always_comb begin
        wr_en   = clr_wr | do_store;
        wr_idx  = clr_wr ? clr_cnt : idx;
        wr_data = clr_wr ? 32'h0 : st_word;
        wr_be   = clr_wr ? 4'hF : st_be;
    end

    // Array write with byte enables and registered read; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
        if (do_load) begin
            rd_word <= mem[idx];
        end
    end

    // Response registers: one-cycle pulse per accepted request, dropped by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            load_ok      <= 1'b0;
            rsp_size     <= SIZE_B;
            rsp_lane     <= 2'b00;
            rsp_unsigned <= 1'b0;
        end else begin
            rsp_valid_q <= accept;
            rsp_err_q   <= accept & req_err;
            load_ok     <= do_load;
            if (accept) begin
                rsp_size     <= bus.req_size;
                rsp_lane     <= lane;
                rsp_unsigned <= bus.req_unsigned;
            end
        end
    end

    // Read data is forced to zero unless this cycle carries a good load result.
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = load_ok ? ld_data : 32'h0;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios plus randomized traffic
// compared against a byte-array reference model.
// Responses are sampled 1 time unit after the accepting clock edge.
module tb_data_memory;
    import mem_pkg::*;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] ref_mem [4*DEPTH];

    data_memory_if bus();

    data_memory #(
        .DEPTH          (DEPTH),
        .BASE_ADDR      (BASE),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: byte array, little-endian, plain arithmetic on offsets.
    function automatic void model_access(input logic we, input logic [31:0] addr,
                                         input logic [1:0] size, input logic uns,
                                         input logic [31:0] wdata,
                                         output logic err, output logic [31:0] rdata);
        logic [31:0] off;
        int          nbytes;
        logic [31:0] val;
        off    = addr - BASE;
        nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        err    = (size == 2'd3) || ((off % nbytes) != 0) || (off >= 4 * DEPTH);
        rdata  = 32'h0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < nbytes; i++) ref_mem[off + i] = wdata[8*i +: 8];
            end else begin
                val = 32'h0;
                for (int i = 0; i < nbytes; i++) val = val | (32'(ref_mem[off + i]) << (8 * i));
                if (!uns && nbytes == 1 && val[7])  val = val | 32'hFFFF_FF00;
                if (!uns && nbytes == 2 && val[15]) val = val | 32'hFFFF_0000;
                rdata = val;
            end
        end
    endfunction

    function automatic void model_zero();
        for (int i = 0; i < 4 * DEPTH; i++) ref_mem[i] = 8'h00;
    endfunction

    // Present one request (or idle) for one clock; return just after the edge.
    task automatic send(input logic v, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata);
        bus.req_valid    = v;
        bus.req_we       = we;
        bus.req_addr     = addr;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_wdata    = wdata;
        @(posedge clk);
        #1;
    endtask

    // Count cycles until req_ready, optionally hammering stores meanwhile.
    task automatic wait_ready(input logic poke, output int cycles, output int spurious);
        cycles   = 0;
        spurious = 0;
        while (bus.req_ready !== 1'b1 && cycles < 3000) begin
            bus.req_valid = poke;
            bus.req_we    = 1'b1;
            bus.req_addr  = (cycles % 2 == 0) ? 32'h0 : 32'h3FC;
            bus.req_size  = SIZE_W;
            bus.req_wdata = 32'hFFFF_FFFF;
            @(posedge clk);
            #1;
            cycles++;
            if (bus.rsp_valid !== 1'b0) spurious++;
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        int cyc, sp;
        rst = 1'b1;
        send(1'b0, 1'b0, 32'h0, SIZE_W, 1'b0, 32'h0);
        send(1'b0, 1'b0, 32'h0, SIZE_W, 1'b0, 32'h0);
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
        checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h expected 0", bus.rsp_rdata); end
        checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b expected 0", bus.rsp_err); end
        model_zero();
        rst = 1'b0;
        wait_ready(1'b0, cyc, sp);
        checks++; if (cyc != 1024) begin errors++; $display("FAIL clear_cycles: got %0d expected 1024", cyc); end
        send(1'b1, 1'b0, 32'h3FC, SIZE_W, 1'b0, 32'h0);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL clear_load_3fc: got v=%b e=%b d=%h expected v=1 e=0 d=00000000", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
        end
        send(1'b0, 1'b0, 32'h0, SIZE_W, 1'b0, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic        e;
        logic [31:0] d;
        int          vcnt;
        logic [31:0] exp_d [4];
        logic [31:0] addr  [4];
        logic [1:0]  sz    [4];
        logic        un    [4];
        exp_d = '{32'h0, 32'h0000_00BE, 32'hFFFF_FFDE, 32'hFFFF_DEAD};
        addr  = '{32'h100, 32'h101, 32'h103, 32'h102};
        sz    = '{SIZE_W, SIZE_B, SIZE_B, SIZE_H};
        un    = '{1'b0, 1'b1, 1'b0, 1'b0};
        vcnt  = 0;
        for (int i = 0; i < 4; i++) begin
            model_access(i == 0, addr[i], sz[i], un[i], 32'hDEAD_BEEF, e, d);
            send(1'b1, i == 0, addr[i], sz[i], un[i], 32'hDEAD_BEEF);
            if (bus.rsp_valid === 1'b1) vcnt++;
            checks++; if (bus.rsp_err !== 1'b0 || bus.rsp_rdata !== exp_d[i]) begin
                errors++; $display("FAIL b2b_%0d: got e=%b d=%h expected e=0 d=%h", i, bus.rsp_err, bus.rsp_rdata, exp_d[i]);
            end
        end
        checks++; if (vcnt != 4) begin errors++; $display("FAIL b2b_valid_run: got %0d expected 4", vcnt); end
        send(1'b0, 1'b0, 32'h0, SIZE_W, 1'b0, 32'h0);
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL idle_no_rsp: got %b expected 0", bus.rsp_valid); end
    endtask

    task automatic test_partial_store();
        logic        e;
        logic [31:0] d;
        model_access(1'b1, 32'h102, SIZE_B, 1'b0, 32'h0000_005A, e, d);
        send(1'b1, 1'b1, 32'h102, SIZE_B, 1'b0, 32'h0000_005A);
        model_access(1'b0, 32'h100, SIZE_W, 1'b0, 32'h0, e, d);
        send(1'b1, 1'b0, 32'h100, SIZE_W, 1'b0, 32'h0);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'hDE5A_BEEF) begin
            errors++; $display("FAIL partial_store: got v=%b e=%b d=%h expected v=1 e=0 d=de5abeef", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
        end
        send(1'b0, 1'b0, 32'h0, SIZE_W, 1'b0, 32'h0);
    endtask

    task automatic test_errors();
        logic        e;
        logic [31:0] d;
        logic        we   [3];
        logic [31:0] addr [3];
        logic [1:0]  sz   [3];
        we   = '{1'b0, 1'b1, 1'b0};
        addr = '{32'h101, 32'h1000, 32'h100};
        sz   = '{SIZE_H, SIZE_W, SIZE_RSV};
        for (int i = 0; i < 3; i++) begin
            model_access(we[i], addr[i], sz[i], 1'b0, 32'h1234_5678, e, d);
            send(1'b1, we[i], addr[i], sz[i], 1'b0, 32'h1234_5678);
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
                errors++; $display("FAIL error_%0d: got v=%b e=%b d=%h expected v=1 e=1 d=00000000", i, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
            end
        end
        send(1'b1, 1'b0, 32'h100, SIZE_W, 1'b0, 32'h0);
        checks++; if (bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'hDE5A_BEEF) begin
            errors++; $display("FAIL after_errors: got e=%b d=%h expected e=0 d=de5abeef", bus.rsp_err, bus.rsp_rdata);
        end
        send(1'b0, 1'b0, 32'h0, SIZE_W, 1'b0, 32'h0);
    endtask

    task automatic test_random();
        logic        v, we, uns, e;
        logic [1:0]  sz;
        logic [31:0] addr, wd, d;
        int          r, bad;
        bad = 0;
        for (int n = 0; n < 400; n++) begin
            v   = ($urandom_range(0, 7) != 0);
            we  = $urandom_range(0, 1);
            uns = $urandom_range(0, 1);
            sz  = 2'($urandom_range(0, 3));
            wd  = $urandom;
            r   = $urandom_range(0, 9);
            if (r == 0)      addr = 32'h1000 + 32'($urandom_range(0, 255));
            else if (r == 1) addr = $urandom;
            else if (r < 6)  addr = 32'($urandom_range(0, 63));
            else             addr = 32'($urandom_range(0, 4095));
            if (r >= 3 && sz == SIZE_H) addr[0] = 1'b0;
            if (r >= 3 && sz == SIZE_W) addr[1:0] = 2'b00;
            e = 1'b0;
            d = 32'h0;
            if (v) model_access(we, addr, sz, uns, wd, e, d);
            send(v, we, addr, sz, uns, wd);
            checks++;
            if (bus.rsp_valid !== v || (v && (bus.rsp_err !== e || bus.rsp_rdata !== d))) begin
                errors++;
                if (bad < 10) $display("FAIL random_%0d: got v=%b e=%b d=%h expected v=%b e=%b d=%h (we=%b a=%h sz=%0d u=%b)",
                                      n, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, v, e, d, we, addr, sz, uns);
                bad++;
            end
        end
        send(1'b0, 1'b0, 32'h0, SIZE_W, 1'b0, 32'h0);
    endtask

    task automatic test_reset_mid_clear();
        int cyc, sp;
        rst = 1'b1;
        send(1'b1, 1'b0, 32'h100, SIZE_W, 1'b0, 32'h0);
        checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0) begin
            errors++; $display("FAIL reset_drops_rsp: got v=%b e=%b d=%h expected all 0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
        end
        send(1'b0, 1'b0, 32'h0, SIZE_W, 1'b0, 32'h0);
        rst = 1'b0;
        repeat (500) begin @(posedge clk); #1; end
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL mid_clear_ready: got %b expected 0", bus.req_ready); end
        rst = 1'b1;
        send(1'b0, 1'b0, 32'h0, SIZE_W, 1'b0, 32'h0);
        rst = 1'b0;
        model_zero();
        wait_ready(1'b0, cyc, sp);
        checks++; if (cyc != 1024) begin errors++; $display("FAIL restart_clear_cycles: got %0d expected 1024", cyc); end
    endtask

    task automatic test_request_during_clear();
        int cyc, sp;
        rst = 1'b1;
        send(1'b0, 1'b0, 32'h0, SIZE_W, 1'b0, 32'h0);
        send(1'b0, 1'b0, 32'h0, SIZE_W, 1'b0, 32'h0);
        rst = 1'b0;
        model_zero();
        wait_ready(1'b1, cyc, sp);
        checks++; if (sp != 0) begin errors++; $display("FAIL clear_ignores_req: got %0d responses expected 0", sp); end
        checks++; if (cyc != 1024) begin errors++; $display("FAIL poked_clear_cycles: got %0d expected 1024", cyc); end
        send(1'b1, 1'b0, 32'h0, SIZE_W, 1'b0, 32'h0);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL word0_after_clear: got v=%b d=%h expected v=1 d=00000000", bus.rsp_valid, bus.rsp_rdata);
        end
        send(1'b1, 1'b0, 32'h3FC, SIZE_W, 1'b0, 32'h0);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL word3fc_after_clear: got v=%b d=%h expected v=1 d=00000000", bus.rsp_valid, bus.rsp_rdata);
        end
        send(1'b0, 1'b0, 32'h0, SIZE_W, 1'b0, 32'h0);
    endtask

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_size     = SIZE_W;
        bus.req_unsigned = 1'b0;
        bus.req_wdata    = 32'h0;
        test_reset();
        test_back_to_back();
        test_partial_store();
        test_errors();
        test_random();
        test_reset_mid_clear();
        test_request_during_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Parametrised, single-port, byte-addressed data memory for the CPU load/store path.
- Successor to the fixed 32-bit word memory: adds byte, half and word accesses, sign/zero extension on loads, a registered read with a valid/ready handshake, alignment and range error reporting, and a hardware clear sequence after reset.
- Sits between the execute/memory stage and the data RAM array.

Parameters:
- DEPTH, 1024, number of 32-bit words; must be a power of two, at least 2.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to 4*DEPTH.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = skip the clear and go straight to READY.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = reserved.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0; ignored for stores.
- req_wdata  in  32  store data, right-justified (lane 0 = bits 7:0).
- rsp_valid  out  1  one-cycle pulse: response for the previously accepted request.
- rsp_rdata  out  32  load result after extension; 0 for stores and errors.
- rsp_err  out  1  request was misaligned, out of range, or used size 11.

Behaviour:
- Reset is synchronous and active-high on rst, sampled at the clk rising edge. Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, clear counter=0.
- The array contents are not reset directly.
- States:
  - CLEAR: writes 0 to word[cnt] each cycle and increments cnt. Moves to READY after word DEPTH-1 is written, so CLEAR lasts exactly DEPTH cycles. req_ready=0 throughout.
  - READY: req_ready=1. If CLEAR_ON_RESET=0, reset leads directly to READY, and req_ready goes high in the first cycle after rst deasserts.
- A request is accepted when req_valid && req_ready. No backpressure in READY: one request per cycle, full throughput.
- Latency is 1 cycle. The request is accepted at edge N; rsp_valid/rsp_rdata/rsp_err are valid in the cycle after edge N. rsp_valid=0 in every cycle that follows an edge with no accepted request.
- Address: off = req_addr - BASE_ADDR (32-bit wrap). The request is in range iff off < 4*DEPTH. The word index is off[log2(DEPTH)+1:2] and the byte lane is off[1:0].
- Error if any of: size=11, half with off[0]=1, word with off[1:0]!=0, or out of range. On error: no array write, rsp_err=1, rsp_rdata=0.
- Byte order is little-endian.
- Store: at the accept edge, only the enabled byte lanes are written.
  - Byte: lane off[1:0] ← wdata[7:0].
  - Half: lanes off[1]*2 and off[1]*2+1 ← wdata[15:0].
  - Word: all four lanes.
  - Response: rsp_err=0, rsp_rdata=0.
- Load: reads the word, selects the lane(s), and extends to 32 bits according to req_unsigned. For word loads, req_unsigned has no effect.
- Read-after-write: a load accepted in the cycle after a store to the same word returns the new data. There is no read-during-write on the same edge, because the block has a single port.
- Reset mid-CLEAR: the counter restarts at 0 and the full clear sequence reruns.
- Reset in READY with a response pending: the response is dropped (rsp_valid=0 after the reset edge).
- A request presented during CLEAR is ignored, with no side effects.

Decomposition:
- Shared package mem_pkg:
  - size encodings SIZE_B, SIZE_H, SIZE_W, SIZE_RSV;
  - state encoding ST_CLEAR, ST_READY;
  - function byte_enable(size, lane) returning 4 bits.
- Sub-module mem_lane_align (combinational):
  - store path: wdata shift plus 4-bit byte enable;
  - load path: lane extraction plus sign/zero extension.
  - The top level holds the FSM, clear counter, array, error check and response registers.

Test Plan:
- Clear after reset: rst high 2 cycles, DEPTH=1024, CLEAR_ON_RESET=1 → req_ready rises exactly 1024 cycles after rst deasserts; a subsequent load word at 0x3FC returns 0x00000000.
- Word store, then sub-word loads, issued back to back:
  - store word 0xDEADBEEF at 0x100, then:
  - load byte unsigned 0x101 → 0x000000BE;
  - load byte signed 0x103 → 0xFFFFFFDE;
  - load half signed 0x102 → 0xFFFFDEAD;
  - rsp_valid high for 4 consecutive cycles.
- Partial store: store byte 0x5A at 0x102, then load word 0x100 in the next cycle → 0xDE5ABEEF, rsp_err=0.
- Errors:
  - load half 0x101 → rsp_err=1, rsp_rdata=0;
  - store word 0x12345678 at 0x1000 (out of range) → rsp_err=1;
  - size=11 → rsp_err=1;
  - load word 0x100 afterwards still returns 0xDE5ABEEF.
- Reset mid-CLEAR: assert rst at clear cycle 500 → the clear restarts, and req_ready rises 1024 cycles after the second deassert.
- Request during CLEAR: req_valid=1 store at 0x0 during CLEAR → no rsp_valid; word 0 reads 0 after READY.
